// File: rtl/gray_stream_ctrl.sv
// Frame sequencer: moves one IMG_WIDTH*IMG_HEIGHT frame from the input FIFO to the
// output FIFO through a one-entry hold register, applying pass/grayscale/fill per frame.
module gray_stream_ctrl #(
  parameter int unsigned FIFO_DATA_WIDTH = 32,
  parameter int unsigned IMG_WIDTH       = 720,
  parameter int unsigned IMG_HEIGHT      = 540,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [1:0]                 mode,
  input  logic [23:0]                fill_value,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_WIDTH-1:0]       pix_count,
  output logic                       fifo_in_rd_en,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_in_dout,
  input  logic                       fifo_in_empty,
  output logic                       fifo_out_wr_en,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_out_din,
  input  logic                       fifo_out_full
);

  localparam logic [CNT_WIDTH-1:0] FRAME      = CNT_WIDTH'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [CNT_WIDTH-1:0] FRAME_LAST = CNT_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             mode_q;
  logic [23:0]            fill_q;
  logic                   hold_valid;
  logic [CNT_WIDTH-1:0]   rd_cnt;
  logic [9:0]             sum;
  logic [7:0]             avg;
  logic [23:0]            pix;
  logic [FIFO_DATA_WIDTH-1:0] proc_word;
  logic                   unused_hi;

  assign unused_hi = ^fifo_in_dout[FIFO_DATA_WIDTH-1:24];

  // Pixel operation on the FIFO head word, selected by the mode latched at start
  always_comb begin
    sum = 10'(fifo_in_dout[23:16]) + 10'(fifo_in_dout[15:8]) + 10'(fifo_in_dout[7:0]);
    avg = 8'(sum / 10'd3);
    case (mode_q)
      2'd1:    pix = {avg, avg, avg};
      2'd2:    pix = fill_q;
      default: pix = fifo_in_dout[23:0];
    endcase
    proc_word = FIFO_DATA_WIDTH'(pix);
  end

  // Next state and FIFO handshakes; FIFO strobes are held off while reset is asserted
  always_comb begin
    state_d        = state_q;
    fifo_in_rd_en  = 1'b0;
    fifo_out_wr_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        fifo_out_wr_en = reset && !abort && hold_valid && !fifo_out_full;
        fifo_in_rd_en  = reset && !fifo_in_empty && (rd_cnt < FRAME) &&
                         (!hold_valid || fifo_out_wr_en);
        if (abort)
          state_d = IDLE;
        else if (fifo_out_wr_en && (pix_count == FRAME_LAST))
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      pix_count    <= '0;
      fifo_out_din <= '0;
      hold_valid   <= 1'b0;
      rd_cnt       <= '0;
      mode_q       <= 2'd0;
      fill_q       <= 24'd0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q     <= mode;
            fill_q     <= fill_value;
            rd_cnt     <= '0;
            pix_count  <= '0;
            hold_valid <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            hold_valid <= 1'b0;
          end else begin
            // A same-cycle read refills the hold, so it stays valid
            if (fifo_in_rd_en) begin
              fifo_out_din <= proc_word;
              hold_valid   <= 1'b1;
              rd_cnt       <= rd_cnt + CNT_WIDTH'(1);
            end else if (fifo_out_wr_en) begin
              hold_valid <= 1'b0;
            end
            if (fifo_out_wr_en) pix_count <= pix_count + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gray_stream_ctrl.md
Name: gray_stream_ctrl

Overview:
Frame-level sequencer for the pixel streaming path between the input FIFO and the output FIFO. On `start` it moves exactly one frame (IMG_WIDTH*IMG_HEIGHT words) from the input FIFO to the output FIFO, applying a per-frame selectable pixel operation (pass, grayscale average, constant fill). It holds pixels in a one-entry register so throughput is one pixel per cycle, reports progress, and pulses `done` at end of frame.

Parameters:
FIFO_DATA_WIDTH, 32, FIFO word width; pixel is bits [23:0] (R=[23:16], G=[15:8], B=[7:0]).
IMG_WIDTH, 720, pixels per line.
IMG_HEIGHT, 540, lines per frame.
CNT_WIDTH, 20, width of pixel counters; must hold IMG_WIDTH*IMG_HEIGHT.

Ports:
clock  in  1  single clock, all logic on rising edge.
reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge).
start  in  1  one-cycle request to process a frame; ignored while busy.
abort  in  1  synchronous frame abort.
mode  in  2  0=pass, 1=grayscale avg, 2=constant fill, 3=pass (reserved); sampled on accepted start.
fill_value  in  24  pixel used in mode 2; sampled on accepted start.
busy  out  1  high from accepted start until done/abort.
done  out  1  one-cycle pulse after the last pixel is written.
pix_count  out  CNT_WIDTH  pixels written to the output FIFO in the current/last frame.
fifo_in_rd_en  out  1  pop input FIFO.
fifo_in_dout  in  FIFO_DATA_WIDTH  input FIFO head word (first-word fall-through, valid when not empty).
fifo_in_empty  in  1  input FIFO empty.
fifo_out_wr_en  out  1  push output FIFO.
fifo_out_din  out  FIFO_DATA_WIDTH  output word.
fifo_out_full  in  1  output FIFO full.

Behaviour:
- Reset (reset==0): state=IDLE; busy=0, done=0, pix_count=0, fifo_in_rd_en=0, fifo_out_wr_en=0, fifo_out_din=0, hold_valid=0, rd_cnt=0; latched mode=0, fill=0.
- FRAME = IMG_WIDTH*IMG_HEIGHT.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> latch mode/fill_value, clear rd_cnt and pix_count, go RUN, busy=1 next cycle.
- RUN read rule (combinational): fifo_in_rd_en = !fifo_in_empty && rd_cnt<FRAME && (!hold_valid || fifo_out_wr_en). On rd_en, register the processed word into hold and set hold_valid; rd_cnt++.
- RUN write rule (combinational): fifo_out_wr_en = hold_valid && !fifo_out_full; fifo_out_din = hold register. On wr_en without a same-cycle read, clear hold_valid; pix_count++.
- Simultaneous read and write in one cycle: hold is replaced and stays valid; sustained rate is 1 pixel/cycle; input-to-output latency is 1 cycle.
- Processed word: bits [31:24] always 0. Mode 0/3: dout[23:0]. Mode 1: sum=R+G+B in 10 bits, avg=floor(sum/3) in 8 bits (0..255), output {avg,avg,avg}. Mode 2: fill, and the input word is still popped and discarded.
- RUN -> DONE when pix_count reaches FRAME (i.e. the write of pixel FRAME). DONE: done=1 for one cycle, busy=0, -> IDLE. pix_count holds its final value until the next start.
- Input empty: no read, hold drains if possible. Output full: hold kept, no read if hold occupied, no data loss or duplication.
- Never reads more than FRAME words; extra input words remain in the FIFO for the next frame.
- abort=1 in RUN: next cycle IDLE, hold_valid=0, busy=0, no done; abort has priority over a same-cycle write (wr_en forced 0). abort in IDLE/DONE: ignored.
- start during RUN/DONE: ignored. start and abort in the same cycle in IDLE: start wins.
- reset mid-frame: all state returns to reset values on that edge; the FIFOs are not touched.

Test Plan:
- IMG 4x2, mode 1, 8 words 0x00306090 with FIFOs never empty/full -> 8 writes of 0x00606060 on consecutive cycles, one done pulse, pix_count=8.
- Mode 1 boundaries: 0x00FFFFFF->0x00FFFFFF, 0x00010101->0x00010101, 0x00000002->0x00000000, 0xAB000000->0x00000000.
- Mode 2 fill 0x555555, 8 arbitrary inputs -> 8 writes 0x00555555, input FIFO popped 8 times.
- Mode 0 with fifo_out_full toggling every other cycle and random empty -> output sequence equals input[23:0] in order, no drops or duplicates; 10 words queued -> exactly 8 popped, 2 remain.
- abort after 3 writes -> busy drops next cycle, no done, pix_count=3; a new start then processes a full 8-pixel frame.
- reset=0 asserted mid-frame while wr_en=1 -> next cycle all outputs 0, state IDLE; start pulse while busy has no effect.
